// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for the BCD countdown timer.
// The master drives load, start, pause and load_val. The slave (the timer)
// returns the count and the status flags.
interface bcd_down_timer_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   q;
    logic                  busy;
    logic                  done;
    logic                  zero;

    modport master (
        output load, start, pause, load_val,
        input  q, busy, done, zero
    );

    modport slave (
        input  load, start, pause, load_val,
        output q, busy, done, zero
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer.
// Loads a start value and counts down one step per clk while running.
// It holds while paused and pulses done when the count reaches zero.
// With AUTO_RLD set, it reloads load_val at zero and keeps running.
// All outputs come from registers.
module bcd_down_timer #(
    parameter int DIGITS   = 2,
    parameter bit AUTO_RLD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    bcd_down_timer_if.slave  tmr
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   q_r, q_n;
    logic           busy_r, done_r, zero_r;
    logic           done_n;
    logic [W-1:0]   load_san;

    // Clamp every nibble above 9 to 9, so the count always holds valid BCD.
    function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
        end
        return r;
    endfunction

    // BCD decrement: digit k borrows only when every lower digit is 0.
    // A digit that borrows while at 0 wraps to 9.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                r[4*k +: 4] = (v[4*k +: 4] == 4'd0) ? 4'd9 : v[4*k +: 4] - 4'd1;
            end
            borrow = borrow & (v[4*k +: 4] == 4'd0);
        end
        return r;
    endfunction

    assign load_san = sanitize(tmr.load_val);

    // Next state and next count, with priority load > start > pause > count.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        state_n = state;
        q_n     = q_r;
        done_n  = 1'b0;
        if (tmr.load) begin
            state_n = IDLE;
            q_n     = load_san;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (tmr.start) begin
                        if (q_r == '0) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else if (tmr.pause) begin
                            state_n = PAUSE;
                        end else begin
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    if (tmr.pause) begin
                        state_n = PAUSE;
                    end else if (q_r == W'(1) || q_r == '0) begin
                        // Terminal step: either reload and keep going, or stop at zero.
                        done_n = 1'b1;
                        if (AUTO_RLD) begin
                            q_n = load_san;
                        end else begin
                            q_n     = '0;
                            state_n = DONE;
                        end
                    end else begin
                        q_n = bcd_dec(q_r);
                    end
                end
                PAUSE: begin
                    if (!tmr.pause) state_n = RUN;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, count and status registers. A reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            q_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            zero_r <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            state  <= state_n;
            q_r    <= q_n;
            busy_r <= (state_n == RUN) || (state_n == PAUSE);
            done_r <= done_n;
            zero_r <= (q_n == '0);
        end
    end

    assign tmr.q    = q_r;
    assign tmr.busy = busy_r;
    assign tmr.done = done_r;
    assign tmr.zero = zero_r;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer with two instances, one with AUTO_RLD=0 and one with AUTO_RLD=1.
// Every clocked step pushes its expected outputs to a scoreboard. They are popped and compared after the edge.
module tb_bcd_down_timer;
    typedef struct packed {
        logic       sel;
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_down_timer_if #(.DIGITS(2)) bus0 ();
    bcd_down_timer_if #(.DIGITS(2)) bus1 ();

    bcd_down_timer #(.DIGITS(2), .AUTO_RLD(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .tmr   (bus0.slave)
    );

    bcd_down_timer #(.DIGITS(2), .AUTO_RLD(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .tmr   (bus1.slave)
    );

    function automatic logic [7:0] bcd(input int n);
        logic [3:0] hi, lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus on the selected instance, then compare after the edge.
    task automatic step(input string tag, input bit sel, input bit ld, input bit st, input bit ps,
                        input logic [7:0] val, input logic [7:0] eq,
                        input bit eb, input bit ed, input bit ez);
        exp_t e;
        @(negedge clk);
        bus0.load = 1'b0; bus0.start = 1'b0; bus0.pause = 1'b0;
        bus1.load = 1'b0; bus1.start = 1'b0; bus1.pause = 1'b0;
        if (sel) begin
            bus1.load = ld; bus1.start = st; bus1.pause = ps; bus1.load_val = val;
        end else begin
            bus0.load = ld; bus0.start = st; bus0.pause = ps; bus0.load_val = val;
        end
        sb.push_back('{sel, eq, eb, ed, ez});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".q"},    e.sel ? bus1.q : bus0.q, e.q);
        check({tag, ".busy"}, {7'd0, e.sel ? bus1.busy : bus0.busy}, {7'd0, e.busy});
        check({tag, ".done"}, {7'd0, e.sel ? bus1.done : bus0.done}, {7'd0, e.done});
        check({tag, ".zero"}, {7'd0, e.sel ? bus1.zero : bus0.zero}, {7'd0, e.zero});
    endtask

    initial begin
        reset = 1'b0;
        bus0.load = 1'b0; bus0.start = 1'b0; bus0.pause = 1'b0; bus0.load_val = 8'h00;
        bus1.load = 1'b0; bus1.start = 1'b0; bus1.pause = 1'b0; bus1.load_val = 8'h00;

        // Reset held for three clocks, then released with no further change.
        for (int i = 0; i < 3; i++) step("rst_hold", 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
        @(negedge clk);
        reset = 1'b1;
        step("rst_rel0", 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
        step("rst_rel1", 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1);

        // Full countdown from 12.
        step("ld12",  0, 1, 0, 0, 8'h12, 8'h12, 0, 0, 0);
        step("st12",  0, 0, 1, 0, 8'h12, 8'h12, 1, 0, 0);
        for (int n = 11; n >= 1; n--) step("cnt12", 0, 0, 0, 0, 8'h12, bcd(n), 1, 0, 0);
        step("hit0",  0, 0, 0, 0, 8'h12, 8'h00, 0, 1, 1);
        step("after0", 0, 0, 0, 0, 8'h12, 8'h00, 0, 0, 1);
        step("done_st", 0, 0, 1, 0, 8'h12, 8'h00, 0, 1, 1);
        step("done_hold", 0, 0, 0, 0, 8'h12, 8'h00, 0, 0, 1);

        // Pause in the middle of a count from 25.
        step("ld25", 0, 1, 0, 0, 8'h25, 8'h25, 0, 0, 0);
        step("st25", 0, 0, 1, 0, 8'h25, 8'h25, 1, 0, 0);
        step("c24",  0, 0, 0, 0, 8'h25, 8'h24, 1, 0, 0);
        step("c23",  0, 0, 0, 0, 8'h25, 8'h23, 1, 0, 0);
        step("c22",  0, 0, 0, 0, 8'h25, 8'h22, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("paused", 0, 0, 0, 1, 8'h25, 8'h22, 1, 0, 0);
        step("resume", 0, 0, 0, 0, 8'h25, 8'h22, 1, 0, 0);
        step("c21",  0, 0, 0, 0, 8'h25, 8'h21, 1, 0, 0);
        step("c20",  0, 0, 0, 0, 8'h25, 8'h20, 1, 0, 0);
        step("c19",  0, 0, 0, 0, 8'h25, 8'h19, 1, 0, 0);

        // Borrow wrap, load while running, and nibble sanitizing.
        step("ld10", 0, 1, 0, 0, 8'h10, 8'h10, 0, 0, 0);
        step("st10", 0, 0, 1, 0, 8'h10, 8'h10, 1, 0, 0);
        step("wrap09", 0, 0, 0, 0, 8'h10, 8'h09, 1, 0, 0);
        step("ldA3", 0, 1, 0, 0, 8'hA3, 8'h93, 0, 0, 0);
        step("ldF0", 0, 1, 0, 0, 8'hF0, 8'h90, 0, 0, 0);
        step("stF0", 0, 0, 1, 0, 8'hF0, 8'h90, 1, 0, 0);
        step("c89",  0, 0, 0, 0, 8'hF0, 8'h89, 1, 0, 0);

        // start together with pause in IDLE goes to PAUSE.
        step("ld05", 0, 1, 0, 0, 8'h05, 8'h05, 0, 0, 0);
        step("stps", 0, 0, 1, 1, 8'h05, 8'h05, 1, 0, 0);
        step("ps05", 0, 0, 0, 1, 8'h05, 8'h05, 1, 0, 0);
        step("rs05", 0, 0, 0, 0, 8'h05, 8'h05, 1, 0, 0);
        step("c04",  0, 0, 0, 0, 8'h05, 8'h04, 1, 0, 0);

        // start with a zero count goes straight to DONE with a done pulse.
        step("ld00", 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1);
        step("st00", 0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 1);

        // Auto-reload instance.
        step("ar_ld03", 1, 1, 0, 0, 8'h03, 8'h03, 0, 0, 0);
        step("ar_st",   1, 0, 1, 0, 8'h03, 8'h03, 1, 0, 0);
        step("ar_02",   1, 0, 0, 0, 8'h03, 8'h02, 1, 0, 0);
        step("ar_01",   1, 0, 0, 0, 8'h03, 8'h01, 1, 0, 0);
        step("ar_rld",  1, 0, 0, 0, 8'h03, 8'h03, 1, 1, 0);
        step("ar_02b",  1, 0, 0, 0, 8'h03, 8'h02, 1, 0, 0);
        step("ar_01b",  1, 0, 0, 0, 8'h03, 8'h01, 1, 0, 0);
        step("ar_rld2", 1, 0, 0, 0, 8'h03, 8'h03, 1, 1, 0);

        // Asynchronous reset between edges while counting.
        step("ld50", 0, 1, 0, 0, 8'h50, 8'h50, 0, 0, 0);
        step("st50", 0, 0, 1, 0, 8'h50, 8'h50, 1, 0, 0);
        step("c49",  0, 0, 0, 0, 8'h50, 8'h49, 1, 0, 0);
        step("c48",  0, 0, 0, 0, 8'h50, 8'h48, 1, 0, 0);
        #3;
        reset = 1'b0;
        #1;
        check("async.q",    bus0.q, 8'h00);
        check("async.busy", {7'd0, bus0.busy}, 8'h00);
        check("async.zero", {7'd0, bus0.zero}, 8'h01);
        check("async.ar_q", bus1.q, 8'h00);
        step("async_hold", 0, 0, 0, 0, 8'h50, 8'h00, 0, 0, 1);
        @(negedge clk);
        reset = 1'b1;
        step("async_rel", 0, 0, 0, 0, 8'h50, 8'h00, 0, 0, 1);

        // load while running returns to IDLE, and counting needs a fresh start.
        step("ld40", 0, 1, 0, 0, 8'h40, 8'h40, 0, 0, 0);
        step("st40", 0, 0, 1, 0, 8'h40, 8'h40, 1, 0, 0);
        step("c39",  0, 0, 0, 0, 8'h40, 8'h39, 1, 0, 0);
        step("ld17run", 0, 1, 0, 0, 8'h17, 8'h17, 0, 0, 0);
        step("idle17",  0, 0, 0, 0, 8'h17, 8'h17, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
